// File: rtl/cmp_bist_pkg.sv
// cmp_bist_pkg: shared types and constants for the comparator BIST.
// Holds the FSM states, LFSR taps/seed, expected-flag struct and LFSR step.
package cmp_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        FIN
    } state_t;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef struct packed {
        logic       eq;
        logic       ae;
        logic       gt;
        logic [3:0] d;
    } flags_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cmp_ref.sv
// cmp_ref: combinational reference comparator producing expected flags.
// Ports: a, b operands in; eq, ae, gt, d[3:0] expected flags out.
module cmp_ref (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        eq,
    output logic        ae,
    output logic        gt,
    output logic [3:0]  d
);

    logic [15:0] abs_a;
    logic [15:0] abs_b;

    // 16'h8000 negates to itself, which is the wanted magnitude
    always_comb begin
        abs_a = a[15] ? (~a + 16'd1) : a;
        abs_b = b[15] ? (~b + 16'd1) : b;
    end

    assign eq   = (a == b);
    assign ae   = (abs_a == abs_b);
    assign gt   = ($signed(a) > $signed(b));
    assign d[0] = (a[3:0]   == b[3:0]);
    assign d[1] = (a[7:4]   == b[7:4]);
    assign d[2] = (a[11:8]  == b[11:8]);
    assign d[3] = (a[15:12] == b[15:12]);

endmodule

// File: rtl/cmp_bist.sv
// cmp_bist: BIST engine driving LFSR operand pairs into a comparator.
// Ports: clk, rst_n, start, n_vec, settle in; A, B out; eq, ae, gt, d in;
//        busy, done, pass, err_cnt, fail_A, fail_B status out.
module cmp_bist
    import cmp_bist_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  n_vec,
    input  logic [7:0]  settle,
    output logic [15:0] A,
    output logic [15:0] B,
    input  logic        eq,
    input  logic        ae,
    input  logic        gt,
    input  logic [3:0]  d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [15:0] fail_A,
    output logic [15:0] fail_B
);

    localparam logic [15:0] SEED_EFF =
        (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    state_t      state;
    logic [15:0] lfsr;
    logic [7:0]  nv;
    logic [7:0]  st;
    logic [7:0]  cnt;
    logic [7:0]  idx;

    logic [15:0] lfsr_n;
    logic [15:0] b_sel;
    logic        last;
    logic        mism;
    flags_t      exp_f;
    flags_t      got_f;

    logic        r_eq;
    logic        r_ae;
    logic        r_gt;
    logic [3:0]  r_d;

    cmp_ref u_ref (
        .a  (A),
        .b  (B),
        .eq (r_eq),
        .ae (r_ae),
        .gt (r_gt),
        .d  (r_d)
    );

    always_comb begin
        lfsr_n = lfsr_step(lfsr);
        b_sel  = lfsr_n;
        unique case (idx[1:0])
            2'd0: b_sel = lfsr_n;
            2'd1: b_sel = ~lfsr_n + 16'd1;
            2'd2: b_sel = lfsr_n ^ 16'hF000;
            2'd3: b_sel = lfsr_step(lfsr_n);
            default: b_sel = lfsr_n;
        endcase
    end

    always_comb begin
        exp_f.eq = r_eq;
        exp_f.ae = r_ae;
        exp_f.gt = r_gt;
        exp_f.d  = r_d;
        got_f.eq = eq;
        got_f.ae = ae;
        got_f.gt = gt;
        got_f.d  = d;
    end

    assign mism = (exp_f != got_f);
    assign last = (({1'b0, idx} + 9'd1) >= {1'b0, nv});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= SEED_EFF;
            nv      <= 8'd0;
            st      <= 8'd1;
            cnt     <= 8'd0;
            idx     <= 8'd0;
            A       <= 16'd0;
            B       <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= 8'd0;
            fail_A  <= 16'd0;
            fail_B  <= 16'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        nv      <= n_vec;
                        st      <= (settle == 8'd0) ? 8'd1 : settle;
                        idx     <= 8'd0;
                        err_cnt <= 8'd0;
                        fail_A  <= 16'd0;
                        fail_B  <= 16'd0;
                        pass    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= (n_vec == 8'd0) ? FIN : DRIVE;
                    end
                end
                DRIVE: begin
                    lfsr  <= lfsr_n;
                    A     <= lfsr_n;
                    B     <= b_sel;
                    cnt   <= st;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mism) begin
                        if (err_cnt != 8'd255) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        // zero count means this is the first miss
                        if (err_cnt == 8'd0) begin
                            fail_A <= A;
                            fail_B <= B;
                        end
                    end
                    if (last) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= DRIVE;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    pass  <= (err_cnt == 8'd0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
